ln_matrix_packer: RTL
=====================

Name: ln_matrix_packer

Overview:
- Producer-side front end for the layer-norm block.
- Accepts a row-major element stream over a valid/ready handshake and assembles a SEQ_LEN x EMB_DIM matrix into a flat bus.
- Pulses start to the downstream consumer, then holds the bus stable until the consumer returns done.
- Counterpart of the consumer's flat-input / start / done interface.

Parameters:
- DATA_WIDTH, 16, bits per element (signed fixed-point, passed through untouched)
- SEQ_LEN, 8, rows (tokens) per matrix
- EMB_DIM, 8, elements per row

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  stream element valid
- in_data  in  DATA_WIDTH  stream element
- in_last  in  1  marks last element of a row
- in_ready  out  1  packer can accept an element
- mat_out  out  DATA_WIDTH*SEQ_LEN*EMB_DIM  flat matrix; element (r,c) at bits [(r*EMB_DIM+c)*DATA_WIDTH +: DATA_WIDTH]
- start  out  1  one-cycle pulse to the consumer
- done  in  1  consumer completion pulse
- busy  out  1  high from start pulse until done is received
- err_row_len  out  1  sticky row-length violation flag

Behaviour:
- Reset (rst=1 at posedge) from any state, including mid-fill or mid-wait:
  - state=S_FILL, row/col=0, buffer all zero.
  - start=0, busy=0, err_row_len=0, in_ready=0 (goes to 1 the cycle after rst deasserts).
- States:
  - S_FILL: in_ready=1. An element is accepted on a cycle with in_valid & in_ready and is written to buffer[row][col].
  - S_ISSUE: in_ready=0, start=1 for exactly this one cycle, busy=1; next state S_WAIT.
  - S_WAIT: in_ready=0, busy=1. When done=1 → S_FILL: buffer zeroed, row/col=0, busy=0. err_row_len is not cleared here.
- Column/row advance on each accepted element:
  - col < EMB_DIM-1 and in_last=0: col++.
  - col < EMB_DIM-1 and in_last=1 (short row): remaining columns of this row stay zero, err_row_len<=1, col=0, row++.
  - col == EMB_DIM-1 and in_last=1: col=0, row++.
  - col == EMB_DIM-1 and in_last=0 (long row): element stored, err_row_len<=1, col=0, row++. The next element starts the next row.
- Matrix completion: accepting the element that finishes row SEQ_LEN-1 moves the FSM to S_ISSUE on the next cycle.
  - Latency: final accept at edge N → start=1 during cycle N+1.
- mat_out is driven directly from the buffer register. It is stable from S_ISSUE through the cycle done is sampled.
- done in S_FILL or S_ISSUE is ignored (no state change, no error).
- done coincident with the start pulse is ignored. Only done sampled in S_WAIT counts.
- in_ready is registered-state decoded (no combinational path from in_valid).
- No arithmetic on data; widths are carried verbatim. Index math uses $clog2 widths; row never wraps beyond SEQ_LEN-1.
- err_row_len clears only on rst.

Optional Feature:
- Macro: LN_PACK_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset 0.
  - Increments on each done accepted in S_WAIT; wraps 16'hFFFF → 0.
- Undefined:
  - Port absent; no counter logic.

Test Plan:
- Full matrix: stream 64 elements, value = r*8+c, in_last on every 8th → start pulse exactly 1 cycle after the 64th accept; mat_out element (3,5)=16'd29; busy=1; in_ready=0.
- Backpressure hold: after start, keep in_valid=1 for 20 cycles, no done → in_ready stays 0, mat_out unchanged. Then done=1 → next cycle in_ready=1, busy=0, mat_out all zero.
- Short row: row 2 sends 3 elements (0xAAAA) with in_last on the 3rd → row 2 cols 3..7 = 0, err_row_len=1, next element lands at (3,0).
- Long row: row 0 col 7 accepted with in_last=0 → err_row_len=1, next element lands at (1,0), matrix completes after 64 total accepts.
- Reset mid-operation: rst=1 during S_WAIT and again after 30 accepts → busy=0, start=0, err cleared, buffer zero, next accept lands at (0,0).
- Spurious done: done=1 during S_FILL after 10 accepts → ignored, fill continues to (1,2). With LN_PACK_FRAME_CNT_EN defined: three completed frames → frame_cnt=3.

Source files
------------

// File: rtl/ln_matrix_packer.sv
// ln_matrix_packer: assembles a row-major element stream into a flat matrix, pulses start and holds it until done.
// Optional LN_PACK_FRAME_CNT_EN adds a 16-bit count of completed frames.
module ln_matrix_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN = 8,
  parameter int EMB_DIM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic in_last,
  output logic in_ready,
  output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] mat_out,
  output logic start,
  input  logic done,
  output logic busy,
  output logic err_row_len
`ifdef LN_PACK_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  localparam int RW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
  localparam int CW = EMB_DIM > 1 ? $clog2(EMB_DIM) : 1;
  localparam logic [1:0] S_FILL = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2;
  logic [1:0] state, state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [31:0] idx;
  logic acc, col_end, row_end, frame_end;
  assign acc = in_valid & in_ready;
  assign col_end = col == CW'(EMB_DIM - 1);
  assign row_end = in_last | col_end;
  assign frame_end = acc & row_end & (row == RW'(SEQ_LEN - 1));
  assign idx = 32'(row) * 32'(EMB_DIM) + 32'(col);
  assign start = state == S_ISSUE;
  assign busy = state != S_FILL;
  always_comb begin
    state_nx = state == S_FILL  ? (frame_end ? S_ISSUE : S_FILL) :
               state == S_ISSUE ? S_WAIT : (done ? S_FILL : S_WAIT);
  end
  // in_ready is registered from the next state so it stays low for the cycle rst is held
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
      row <= '0;
      col <= '0;
      mat_out <= '0;
      err_row_len <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state <= state_nx;
      in_ready <= state_nx == S_FILL;
      if (acc) begin
        mat_out[idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        if (in_last != col_end) err_row_len <= 1'b1;
        col <= row_end ? '0 : col + 1'b1;
        row <= !row_end ? row : frame_end ? '0 : row + 1'b1;
      end
      if (state == S_WAIT && done) mat_out <= '0;
    end
  end
`ifdef LN_PACK_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else if (state == S_WAIT && done) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule
